// File: rtl/cpu_pkg.sv
// Shared opcodes, IR field positions, sequencer states and opcode classification.
// Used by control_sequencer; CTRL_MULDIV_EN handling lives in the top, not here.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam int SEL_W    = 13;
  localparam int SEL_ADD  = 0;
  localparam int SEL_SUB  = 1;
  localparam int SEL_AND  = 2;
  localparam int SEL_OR   = 3;
  localparam int SEL_SHR  = 4;
  localparam int SEL_SHRA = 5;
  localparam int SEL_SHL  = 6;
  localparam int SEL_ROR  = 7;
  localparam int SEL_ROL  = 8;
  localparam int SEL_MUL  = 9;
  localparam int SEL_DIV  = 10;
  localparam int SEL_NEG  = 11;
  localparam int SEL_NOT  = 12;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_UNARY, CL_MULDIV, CL_HALT
  } op_class_t;

  // Unknown opcodes fall into CL_NOP so they retire after T3.
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       c = CL_ALU;
      OP_NEG, OP_NOT:                        c = CL_UNARY;
      OP_MUL, OP_DIV:                        c = CL_MULDIV;
      OP_HALT:                               c = CL_HALT;
      default:                               c = CL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [SEL_W-1:0] op_select(input logic [4:0] op);
    logic [SEL_W-1:0] s;
    s = '0;
    case (op)
      OP_ADD:  s[SEL_ADD]  = 1'b1;
      OP_SUB:  s[SEL_SUB]  = 1'b1;
      OP_AND:  s[SEL_AND]  = 1'b1;
      OP_OR:   s[SEL_OR]   = 1'b1;
      OP_SHR:  s[SEL_SHR]  = 1'b1;
      OP_SHRA: s[SEL_SHRA] = 1'b1;
      OP_SHL:  s[SEL_SHL]  = 1'b1;
      OP_ROR:  s[SEL_ROR]  = 1'b1;
      OP_ROL:  s[SEL_ROL]  = 1'b1;
      OP_MUL:  s[SEL_MUL]  = 1'b1;
      OP_DIV:  s[SEL_DIV]  = 1'b1;
      OP_NEG:  s[SEL_NEG]  = 1'b1;
      OP_NOT:  s[SEL_NOT]  = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_decode4to16.sv
// 4-bit register index to one-hot GPR enable; all zeros when en_i is low.
// Purely combinational.
module reg_decode4to16 (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving DataPath strobes as Moore decodes of state and IR.
// Define CTRL_MULDIV_EN to enable the mul/div T3-T6 sequence; otherwise mul/div retire as nop.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IR_W = 32
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Start,
  input  logic            Stop,
  input  logic [IR_W-1:0] IR,
  output logic            Run,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            HIin,
  output logic            LOin,
  output logic [15:0]     Rin,
  output logic [15:0]     Rout,
  output logic            ADD,
  output logic            SUB,
  output logic            AND,
  output logic            OR,
  output logic            SHR,
  output logic            SHRA,
  output logic            SHL,
  output logic            ROR,
  output logic            ROL,
  output logic            MUL,
  output logic            DIV,
  output logic            NEG,
  output logic            NOT
);

  state_t           state_q, state_d;
  op_class_t        cls;
  logic [4:0]       opcode;
  logic [3:0]       ra, rb, rc;
  logic [SEL_W-1:0] sel;
  logic             sel_en;
  logic             last;
  logic             rin_en, rout_en;
  logic [3:0]       rout_idx;
  logic             unused_ir;

  assign opcode    = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign sel       = op_select(opcode);
  assign unused_ir = ^IR[RC_LSB-1:0];

  always_comb begin
`ifdef CTRL_MULDIV_EN
    cls = op_class(opcode);
`else
    cls = op_class(opcode);
    if (cls == CL_MULDIV) cls = CL_NOP;
`endif
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    last     = 1'b0;
    Run      = 1'b0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    Read     = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    sel_en   = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rb;

    unique case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_T0;
      end
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        Run = 1'b1;
        case (cls)
          CL_ALU: begin
            rout_en = 1'b1; rout_idx = rb; Yin = 1'b1; state_d = S_T4;
          end
          CL_UNARY: begin
            rout_en = 1'b1; rout_idx = rb; sel_en = 1'b1; Zin = 1'b1; state_d = S_T4;
          end
          CL_MULDIV: begin
            rout_en = 1'b1; rout_idx = ra; Yin = 1'b1; state_d = S_T4;
          end
          CL_HALT: state_d = S_HALT;
          default: last = 1'b1;
        endcase
      end
      S_T4: begin
        Run = 1'b1;
        case (cls)
          CL_ALU: begin
            rout_en = 1'b1; rout_idx = rc; sel_en = 1'b1; Zin = 1'b1; state_d = S_T5;
          end
          CL_MULDIV: begin
            rout_en = 1'b1; rout_idx = rb; sel_en = 1'b1; Zin = 1'b1; state_d = S_T5;
          end
          CL_UNARY: begin
            Zlowout = 1'b1; rin_en = 1'b1; last = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T5: begin
        Run = 1'b1;
        case (cls)
          CL_ALU: begin
            Zlowout = 1'b1; rin_en = 1'b1; last = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          CL_MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1; state_d = S_T6;
          end
`endif
          default: last = 1'b1;
        endcase
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        Run = 1'b1; Zhighout = 1'b1; HIin = 1'b1; last = 1'b1;
      end
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Stop only matters at the retiring state of an instruction.
    if (last) state_d = Stop ? S_HALT : S_T0;
  end

  reg_decode4to16 u_rin_dec (
    .idx_i    (ra),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  reg_decode4to16 u_rout_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

  assign ADD  = sel_en & sel[SEL_ADD];
  assign SUB  = sel_en & sel[SEL_SUB];
  assign AND  = sel_en & sel[SEL_AND];
  assign OR   = sel_en & sel[SEL_OR];
  assign SHR  = sel_en & sel[SEL_SHR];
  assign SHRA = sel_en & sel[SEL_SHRA];
  assign SHL  = sel_en & sel[SEL_SHL];
  assign ROR  = sel_en & sel[SEL_ROR];
  assign ROL  = sel_en & sel[SEL_ROL];
  assign NEG  = sel_en & sel[SEL_NEG];
  assign NOT  = sel_en & sel[SEL_NOT];

`ifdef CTRL_MULDIV_EN
  assign MUL  = sel_en & sel[SEL_MUL];
  assign DIV  = sel_en & sel[SEL_DIV];
`else
  logic unused_sel;
  assign MUL        = 1'b0;
  assign DIV        = 1'b0;
  assign unused_sel = sel[SEL_MUL] ^ sel[SEL_DIV];
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: per-instruction expected strobe sequences built from the opcode table and compared every cycle.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, Start, Stop;
  logic [31:0] IR;
  logic        Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;

  always #5 Clock = ~Clock;

  control_sequencer #(.IR_W(32)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop), .IR(IR),
    .Run(Run), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT)
  );

  // Strobe positions inside ctl_t.strb, and ALU select positions inside ctl_t.sel.
  localparam logic [13:0] PC_O = 14'h2000, PC_I = 14'h1000, INC = 14'h0800, MAR = 14'h0400;
  localparam logic [13:0] MDR_I = 14'h0200, MDR_O = 14'h0100, RD = 14'h0080, IR_I = 14'h0040;
  localparam logic [13:0] Y_I = 14'h0020, Z_I = 14'h0010, ZH_O = 14'h0008, ZL_O = 14'h0004;
  localparam logic [13:0] HI_I = 14'h0002, LO_I = 14'h0001;

  typedef struct packed {
    logic        run;
    logic [13:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [12:0] sel;   // {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,MUL,DIV,NEG,NOT}
  } ctl_t;

  logic [63:0] obs;
  assign obs = {4'b0, Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                Yin, Zin, Zhighout, Zlowout, HIin, LOin, Rin, Rout,
                ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT};

  int   n_cmp = 0;
  int   n_bad = 0;
  ctl_t exp_q[$];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t mk(logic [13:0] s, logic [15:0] rin, logic [15:0] rout, logic [12:0] sel);
    ctl_t c;
    c.run = 1'b1; c.strb = s; c.rin = rin; c.rout = rout; c.sel = sel;
    return c;
  endfunction

  function automatic logic [15:0] oh(logic [3:0] n);
    return 16'(1) << n;
  endfunction

  // kind: 0 nop, 1 three-operand ALU, 2 neg/not, 3 mul/div, 4 halt
  task automatic classify(input logic [4:0] op, output int kind, output logic [12:0] sel);
    sel = '0;
    kind = 0;
    case (op)
      5'd3:  begin kind = 1; sel[12] = 1'b1; end
      5'd4:  begin kind = 1; sel[11] = 1'b1; end
      5'd5:  begin kind = 1; sel[10] = 1'b1; end
      5'd6:  begin kind = 1; sel[9]  = 1'b1; end
      5'd7:  begin kind = 1; sel[5]  = 1'b1; end
      5'd8:  begin kind = 1; sel[4]  = 1'b1; end
      5'd9:  begin kind = 1; sel[8]  = 1'b1; end
      5'd10: begin kind = 1; sel[7]  = 1'b1; end
      5'd11: begin kind = 1; sel[6]  = 1'b1; end
      5'd15: begin kind = 3; sel[3]  = 1'b1; end
      5'd16: begin kind = 3; sel[2]  = 1'b1; end
      5'd17: begin kind = 2; sel[1]  = 1'b1; end
      5'd18: begin kind = 2; sel[0]  = 1'b1; end
      5'd27: kind = 4;
      default: kind = 0;
    endcase
`ifndef CTRL_MULDIV_EN
    if (kind == 3) begin kind = 0; sel = '0; end
`endif
  endtask

  // Fills exp_q with the full T0..last sequence; is_halt marks the halt opcode.
  task automatic build(input logic [31:0] ir, output bit is_halt);
    int          kind;
    logic [12:0] sel;
    logic [3:0]  ra, rb, rc;
    ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    classify(ir[31:27], kind, sel);
    is_halt = (kind == 4);
    exp_q.delete();
    exp_q.push_back(mk(PC_O | MAR | INC | Z_I, 0, 0, 0));
    exp_q.push_back(mk(ZL_O | PC_I | RD | MDR_I, 0, 0, 0));
    exp_q.push_back(mk(MDR_O | IR_I, 0, 0, 0));
    case (kind)
      1: begin
        exp_q.push_back(mk(Y_I, 0, oh(rb), 0));
        exp_q.push_back(mk(Z_I, 0, oh(rc), sel));
        exp_q.push_back(mk(ZL_O, oh(ra), 0, 0));
      end
      2: begin
        exp_q.push_back(mk(Z_I, 0, oh(rb), sel));
        exp_q.push_back(mk(ZL_O, oh(ra), 0, 0));
      end
      3: begin
        exp_q.push_back(mk(Y_I, 0, oh(ra), 0));
        exp_q.push_back(mk(Z_I, 0, oh(rb), sel));
        exp_q.push_back(mk(ZL_O | LO_I, 0, 0, 0));
        exp_q.push_back(mk(ZH_O | HI_I, 0, 0, 0));
      end
      default: exp_q.push_back(mk(0, 0, 0, 0));
    endcase
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // From any state: pulse Clear, confirm asynchronous zeroing and IDLE, then Start into T0.
  task automatic recover();
    Clear = 1'b1;
    #1 chk_eq("clear_async", obs, 64'h0);
    #2 Clear = 1'b0;
    Start = 1'b0;
    tick();
    chk_eq("idle_hold", obs, 64'h0);
    Start = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [31:0] ir;
    bit          stop;
    int          clr_at;
  } instr_t;

  instr_t prog[$];

  initial begin
    instr_t in;
    bit     is_halt, halted;
    Clear = 1'b1; Start = 1'b1; Stop = 1'b0; IR = '0;
    #12 chk_eq("reset", obs, 64'h0);
    #1 Clear = 1'b0;
    tick();

    prog.push_back('{32'h50918000, 1'b0, -1});
    prog.push_back('{32'h7B380000, 1'b0, -1});
    prog.push_back('{32'h8A280000, 1'b0, -1});
    prog.push_back('{{5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b1, -1});
    prog.push_back('{{5'b00011, 4'd9, 4'd10, 4'd11, 15'd0}, 1'b0, 4});
    prog.push_back('{32'hD8000000, 1'b0, -1});
    for (int k = 0; k < 80; k++) begin
      in.ir     = $urandom;
      in.stop   = ($urandom_range(0, 7) == 0);
      in.clr_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1;
      prog.push_back(in);
    end

    foreach (prog[p]) begin
      in = prog[p];
      IR = in.ir;
      build(in.ir, is_halt);
      halted = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        chk_eq("seq", obs, {4'b0, exp_q[i]});
        Start = 1'($urandom);
        Stop  = (i == exp_q.size() - 1) ? in.stop : 1'($urandom);
        if (i == in.clr_at) begin
          recover();
          halted = 1'b1;
          break;
        end
      end
      if (!halted) begin
        tick();
        if (is_halt || in.stop) begin
          for (int h = 0; h < 3; h++) begin
            chk_eq("halt", obs, 64'h0);
            Start = 1'($urandom);
            tick();
          end
          recover();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the phase-2 CPU. It generates every register-transfer, ALU-select and memory control strobe that `DataPath` consumes, which replaces the hand-driven control sequences used in phase-1 benches. It runs a fixed fetch (T0–T2) and then a per-opcode execute sequence decoded from the datapath IR. It sits beside `DataPath` at CPU top level and drives its control port list directly.

## Interface
- `IR_W`, default 32: IR width.
- `Clock`  in  1: system clock; all state changes on the rising edge.
- `Clear`  in  1: asynchronous, active-high reset.
- `Start`  in  1: leaves IDLE when sampled high.
- `Stop`  in  1: sampled in the last execute state; high sends the unit to HALT instead of the next fetch.
- `IR`  in  IR_W: datapath IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `Run`  out  1: high in every state except IDLE and HALT.
- `PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin`  out  1 each: datapath strobes.
- `Rin, Rout`  out  16 each: one-hot GPR enables; bit n drives Rn.
- `ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT`  out  1 each: ALU selects, at most one high.

## Operation
- Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011. Any other opcode executes as nop.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- IDLE: all outputs 0. Start=1 → T0.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- 3-operand ALU op:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], ALU select, Zin.
  - T5: Zlowout, Rin[Ra]. This is the last state.
- neg/not:
  - T3: Rout[Rb], select, Zin.
  - T4: Zlowout, Rin[Ra]. This is the last state.
- mul/div (Ra × or ÷ Rb):
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], select, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. This is the last state.
- nop: T3 is the last state. It asserts no strobes.
- halt: T3 → HALT.
- Last state: Stop=1 → HALT, otherwise → T0.
- HALT: all outputs 0, Run=0. Only Clear exits HALT.
- Register index fields are decoded as 4-bit values into one-hot; R0 is an ordinary register here.

## Timing
- Outputs are Moore decodes of the registered state and IR fields. They are valid for the full cycle of the state.
- IR is captured by the datapath at the end of T2, so decode uses IR from T3 onward. IR must be stable from T3 until the last state.
- Instruction latency, counted from T0 entry to the next T0 entry:
  - fetch 3 cycles;
  - nop 4;
  - neg/not 5;
  - ALU 6;
  - mul/div 7.
- Clear at any time forces IDLE, with all outputs and Run at 0 immediately (asynchronous). A partially executed instruction is abandoned; no write-back strobe is issued.
- Start is ignored outside IDLE. Stop is ignored outside last states.
- Stop and halt in the same instruction → HALT (same outcome).

## Configuration
- `CTRL_MULDIV_EN` defined: mul/div execute the T3–T6 sequence above.
- Not defined: no T6 state is generated. mul/div decode as nop, and MUL, DIV, HIin, LOin and Zhighout are tied 0.

## Structure
- Package `cpu_pkg`:
  - opcode localparams;
  - state enum;
  - IR field bit positions.
- One sub-module, `reg_decode4to16`: 4-bit index in, enable in, 16-bit one-hot out. Instantiated twice, once for Rin and once for Rout.

## Test plan
- Clear high with Start=1 → all outputs 0, Run=0. After release with Start=1 → T0 cycle shows PCout=MARin=IncPC=Zin=1.
- IR=32'h50918000 (shra R1,R2,R3):
  - T3: Rout=16'h0004, Yin.
  - T4: Rout=16'h0008, SHRA, Zin.
  - T5: Zlowout, Rin=16'h0002.
  - Next cycle is T0.
- IR=32'h7B380000 (mul R6,R7) with `CTRL_MULDIV_EN`:
  - T3: Rout=16'h0040.
  - T4: Rout=16'h0080, MUL.
  - T5: LOin.
  - T6: Zhighout, HIin.
  - Without the macro: T3 is the last state and no strobes are asserted.
- IR=32'h8A280000 (neg R4,R5) → T3: Rout=16'h0020, NEG, Zin. T4: Zlowout, Rin=16'h0010.
- IR=32'hD8000000 (halt) → HALT after T3, Run=0. Start pulses have no effect. Clear → IDLE.
- Stop=1 during T5 of an add → HALT, not T0. Clear asserted mid-T4 → outputs 0 asynchronously and no Rin pulse.
